imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle immediate extractor.
- Extracts and sign-extends the RISC-V I/S/B/U/J immediates to XLEN bits through a 2-stage valid/ready pipeline.
- The immediate format comes either from an external select or from auto-decode of the instruction opcode.
- Sits between fetch/decode and the operand mux; a sideband tag (PC index / ROB id) travels with each instruction.

Parameters:
- XLEN, 32: output immediate width; legal values are 32 and 64.
- TAG_W, 4: width of the sideband tag passed through unchanged.
- AUTO_DECODE, 0: 1 = derive the format from ins[6:0] and ignore in_sel; 0 = use in_sel.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- ins  in  32  instruction word.
- in_sel  in  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm), others illegal.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- imm_out  out  XLEN  extended immediate.
- out_sel  out  3  resolved format (decoded value when AUTO_DECODE=1).
- out_tag  out  TAG_W  tag of the returned beat.
- out_illegal  out  1  format illegal or unsupported; imm_out is 0 when set.

Behaviour:
- Reset: the asynchronous, active-high reset clears s1_valid, s2_valid, out_valid, imm_out, out_sel, out_tag and out_illegal to 0. in_ready is 1 while reset is deasserted and the pipeline is empty.
- Reset mid-operation: in-flight beats are dropped with no partial output.
- Handshake:
  - A beat transfers on in_valid && in_ready, or on out_valid && out_ready.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is a combinational ready chain; there is no skid buffer.
  - s1 advances into s2 when !s2_valid || out_ready.
  - While out_valid && !out_ready, the outputs hold stable.
  - If out_valid=1 and out_ready=1 while s1 is valid in the same cycle, s2 reloads from s1 and s1 can accept a new beat. Sustained throughput is 1 beat/cycle.
- Latency: 2 cycles from the input handshake to out_valid with no stall.
- Stage 1 registers:
  - ins, tag and the resolved format.
  - The illegal flag: in_sel in 110/111, or 101 when Z is not compiled in.
- Stage 2 forms the immediate from the stage-1 registers:
  - I: sign-extend ins[31:20].
  - S: sign-extend {ins[31:25], ins[11:7]}.
  - B: sign-extend {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}.
  - U: {ins[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - J: sign-extend {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}.
  - Z: zero-extend ins[19:15].
  - Illegal: 0.
- Auto-decode (AUTO_DECODE=1), opcode to format:
  - I: 0010011, 0000011, 1100111, 0011011, and 1110011 with funct3[2]=0.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Z: 1110011 with funct3[2]=1.
  - Any other opcode is illegal, with out_sel=111.
- Illegal beats still flow through the pipeline and handshake normally; they are never dropped.
- No state wraps; there are no counters beyond the two stage-valid bits.

Optional Feature:
- Macro IMM_GEN_ZIMM_EN.
- Defined: the Z format (in_sel=101, or auto-decoded CSR-immediate) outputs the zero-extended zimm.
- Undefined: Z is treated as illegal, giving out_illegal=1 and imm_out=0, and the Z datapath is not synthesised.

Test Plan:
1. XLEN=32, sel I, ins=0xFFF00093 (addi x1,x0,-1), out_ready=1 → 2 cycles later: out_valid=1, imm_out=0xFFFFFFFF, out_illegal=0, tag echoed.
2. Back-to-back beats with out_ready=1:
   - S-type 0x00512423 (sw x5,8(x2)) → imm_out=0x00000008.
   - B-type 0xFE000EE3 (beq -4) → imm_out=0xFFFFFFFC on the next cycle.
   - U-type 0x123450B7 (lui 0x12345) → imm_out=0x12345000 on the following cycle.
3. Backpressure: hold out_ready=0 while issuing 3 beats.
   - in_ready drops after 2 accepts.
   - imm_out and out_tag stay stable for the whole stall.
   - Releasing out_ready drains all 3 in order, one per cycle.
4. in_sel=111 and, with the macro undefined, in_sel=101 → out_illegal=1, imm_out=0, order preserved. With IMM_GEN_ZIMM_EN defined, csrrwi zimm=0x1F → imm_out=0x0000001F.
5. XLEN=64, AUTO_DECODE=1:
   - ins=0x800000B7 (lui 0x80000) → imm_out=0xFFFFFFFF80000000, out_sel=011.
   - Unknown opcode 0x0000007F → out_illegal=1.
6. Assert rst with both stages full and out_ready=0 → out_valid=0 and imm_out=0 immediately; after release, in_ready=1 and the first new beat appears 2 cycles after acceptance.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready RISC-V immediate generator (I/S/B/U/J, optional Z).
// Optional CSR zimm (Z) format is compiled in with `define IMM_GEN_ZIMM_EN.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 4,
  parameter int AUTO_DECODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ins,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       out_sel,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] FMT_I   = 3'b000;
  localparam logic [2:0] FMT_S   = 3'b001;
  localparam logic [2:0] FMT_B   = 3'b010;
  localparam logic [2:0] FMT_U   = 3'b011;
  localparam logic [2:0] FMT_J   = 3'b100;
  localparam logic [2:0] FMT_Z   = 3'b101;
  localparam logic [2:0] FMT_BAD = 3'b111;

  logic             r_s1_valid;
  logic [31:7]      r_ins;
  logic [TAG_W-1:0] r_tag;
  logic [2:0]       r_sel;
  logic             r_ill;

  logic             w_s1_adv;
  logic             w_in_fire;
  logic [2:0]       w_sel_res;
  logic             w_ill_res;
  logic [XLEN-1:0]  w_imm;

  // s1 drains whenever s2 is empty or s2 is being consumed this cycle.
  assign w_s1_adv  = !out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_in_fire = in_valid && in_ready;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_sel_res = in_sel;
    if (AUTO_DECODE != 0) begin
      case (ins[6:0])
        7'b0010011, 7'b0000011,
        7'b1100111, 7'b0011011: w_sel_res = FMT_I;
        7'b1110011:             w_sel_res = ins[14] ? FMT_Z : FMT_I;
        7'b0100011:             w_sel_res = FMT_S;
        7'b1100011:             w_sel_res = FMT_B;
        7'b0110111, 7'b0010111: w_sel_res = FMT_U;
        7'b1101111:             w_sel_res = FMT_J;
        default:                w_sel_res = FMT_BAD;
      endcase
    end
    case (w_sel_res)
      FMT_I, FMT_S, FMT_B, FMT_U, FMT_J: w_ill_res = 1'b0;
`ifdef IMM_GEN_ZIMM_EN
      FMT_Z:                             w_ill_res = 1'b0;
`endif
      default:                           w_ill_res = 1'b1;
    endcase
  end

  // Size casts of signed operands sign-extend to XLEN; unsigned ones zero-extend.
  always_comb begin
    w_imm = '0;
    if (!r_ill) begin
      case (r_sel)
        FMT_I: w_imm = XLEN'($signed(r_ins[31:20]));
        FMT_S: w_imm = XLEN'($signed({r_ins[31:25], r_ins[11:7]}));
        FMT_B: w_imm = XLEN'($signed({r_ins[31], r_ins[7], r_ins[30:25], r_ins[11:8], 1'b0}));
        FMT_U: w_imm = XLEN'($signed({r_ins[31:12], 12'b0}));
        FMT_J: w_imm = XLEN'($signed({r_ins[31], r_ins[19:12], r_ins[20], r_ins[30:21], 1'b0}));
`ifdef IMM_GEN_ZIMM_EN
        FMT_Z: w_imm = XLEN'(r_ins[19:15]);
`endif
        default: w_imm = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so both stages update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_ins      <= '0;
      r_tag      <= '0;
      r_sel      <= '0;
      r_ill      <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_ins      <= ins[31:7];
      r_tag      <= in_tag;
      r_sel      <= w_sel_res;
      r_ill      <= w_ill_res;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Output data only changes on a real s1->s2 transfer, so it holds through stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      imm_out     <= '0;
      out_sel     <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (w_s1_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        imm_out     <= w_imm;
        out_sel     <= r_sel;
        out_tag     <= r_tag;
        out_illegal <= r_ill;
      end
    end
  end

endmodule
